alu_result_checker: RTL
=======================

# alu_result_checker

Self-check monitor downstream of the instruction loader and the core it programs. After the loader reports `loader_done`, it computes the golden ALU result from the same `op1`/`op2`/`alu_op` inputs. It then snoops the core's data-memory store and register-file write-back, and raises a sticky pass or fail flag with an error code.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: maximum cycles allowed from arming until the load write-back.
- `RESULT_ADDR`, default 32'h4: data-memory address of the result store.
- `LOAD_REG`, default 5'd12: destination register of the result reload. Must be nonzero.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-low.
- `op1`  in  12: operand 1, same bus the loader consumes.
- `op2`  in  12: operand 2.
- `alu_op`  in  3: ALU opcode select.
- `loader_done`  in  1: loader finished. Level, sticky until reset.
- `dmem_we`  in  1: core data-memory write enable.
- `dmem_addr`  in  32: core data-memory address.
- `dmem_wdata`  in  32: core data-memory write data.
- `rf_we`  in  1: core register-file write enable.
- `rf_waddr`  in  5: register-file write index.
- `rf_wdata`  in  32: register-file write data.
- `busy`  out  1: high while waiting for core events.
- `pass`  out  1: sticky; checks succeeded.
- `fail`  out  1: sticky; a check failed.
- `err_code`  out  2: 00 none, 01 store mismatch, 10 reload mismatch, 11 timeout.
- `observed_result`  out  32: value captured from the result store.

## Operation
- Golden model:
  - Sign-extend `op1` and `op2` to 32 bits, matching ADDI semantics.
  - `alu_op` 000 = add, 001 = sub, 010 = and, 011 = or, 1xx = add.
  - Arithmetic is modulo 2^32; no overflow flag.
- States: IDLE, WAIT_ST, WAIT_LD, PASS, FAIL.
- IDLE:
  - On `loader_done`=1, latch the golden result from the inputs in that cycle into `expected`.
  - Clear the timeout counter and go to WAIT_ST.
  - Core events in IDLE are ignored.
- WAIT_ST:
  - Qualifying event: `dmem_we` && `dmem_addr`==`RESULT_ADDR`.
  - On that event, capture `dmem_wdata` into `observed_result`.
  - If the captured value equals `expected`, go to WAIT_LD; otherwise go to FAIL with err 01.
  - Stores to other addresses and all `rf` writes are ignored.
- WAIT_LD:
  - Qualifying event: `rf_we` && `rf_waddr`==`LOAD_REG`.
  - If `rf_wdata` equals `observed_result`, go to PASS; otherwise go to FAIL with err 10.
  - Further stores to `RESULT_ADDR` are ignored; `observed_result` keeps the first captured value.
- Timeout:
  - The counter increments every cycle in WAIT_ST and WAIT_LD and is not reset between them.
  - When it equals `TIMEOUT_CYCLES`-1 with no qualifying event that cycle, go to FAIL with err 11.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`; it saturates and never wraps.
- Simultaneous events: a qualifying event in the same cycle as timeout expiry takes priority over the timeout.
- PASS and FAIL are terminal until `rst`=0. `loader_done` staying high does not re-arm.

## Timing
- Reset values: `busy`=0, `pass`=0, `fail`=0, `err_code`=00, `observed_result`=0, state IDLE, counter 0.
- Reset taken mid-run returns to IDLE on the next edge and discards `expected`.
- `busy` rises on the edge after `loader_done` is sampled high and falls on the edge entering PASS or FAIL.
- All outputs are registered.
  - `pass`/`fail`/`err_code` update on the clock edge following the qualifying event (1-cycle latency).
  - `observed_result` updates on the same edge as the WAIT_ST to WAIT_LD or FAIL transition.
- Timeout fail is asserted exactly `TIMEOUT_CYCLES` edges after the edge entering WAIT_ST.
- `pass` and `fail` are never high together.

## Structure
- Shared package:
  - ALU opcode constants (ADD/SUB/AND/OR), shared with the loader.
  - `err_code` constants.
  - State enum.
- Sub-module `alu_golden_model`: combinational, maps (`op1`, `op2`, `alu_op`) to a 32-bit expected result. The testbench reuses it as a reference.
- Top level: FSM, timeout counter, capture registers.

## Test plan
- ADD, `op1`=5, `op2`=7: store 32'hC at 0x4, then write 32'hC to r12 → `pass`=1, `err_code`=00, `observed_result`=32'hC.
- SUB, `op1`=3, `op2`=5: store 32'hFFFFFFFE, reload same → `pass`=1. ADD, `op1`=12'h800, `op2`=1: expected 32'hFFFFF801 → `pass`=1.
- AND, `op1`=12'h0F0, `op2`=12'h03C:
  - Store 32'h30 at 0x8, then 32'h31 at 0x4 → `fail`=1, `err_code`=01, `observed_result`=32'h31.
  - The 0x8 store is ignored.
- OR, `op1`=1, `op2`=2: store 32'h3 at 0x4, then write 32'h4 to r12 (after a write to r11) → `fail`=1, `err_code`=10.
- `TIMEOUT_CYCLES`=16, no core activity → `fail`=1, `err_code`=11 exactly 16 edges after WAIT_ST entry. Repeat with the store landing in the expiry cycle → no timeout.
- Assert `rst`=0 in WAIT_LD → all outputs 0 on the next edge. Re-arm with new operands → correct pass.

Source files
------------

// File: rtl/alu_result_checker_pkg.sv
// Shared definitions for the ALU result checker: opcodes, error codes and FSM states.
// The opcode constants match the encoding the instruction loader uses.
package alu_result_checker_pkg;

  localparam logic [2:0] AluOpAdd = 3'b000;
  localparam logic [2:0] AluOpSub = 3'b001;
  localparam logic [2:0] AluOpAnd = 3'b010;
  localparam logic [2:0] AluOpOr  = 3'b011;

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrStore   = 2'b01;
  localparam logic [1:0] ErrReload  = 2'b10;
  localparam logic [1:0] ErrTimeout = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StWaitSt,
    StWaitLd,
    StPass,
    StFail
  } state_e;

  // Operands are immediates, so widen them the way ADDI does.
  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/alu_golden_model.sv
// Combinational reference ALU producing the result the core is expected to store.
// Opcodes 1xx fall back to add.
module alu_golden_model
  import alu_result_checker_pkg::*;
(
  input  logic [11:0] op1_i,
  input  logic [11:0] op2_i,
  input  logic [2:0]  alu_op_i,
  output logic [31:0] result_o
);

  logic [31:0] a, b;

  always_comb begin
    a = sext12(op1_i);
    b = sext12(op2_i);
    case (alu_op_i)
      AluOpSub: result_o = a - b;
      AluOpAnd: result_o = a & b;
      AluOpOr:  result_o = a | b;
      default:  result_o = a + b;
    endcase
  end

endmodule

// File: rtl/alu_result_checker.sv
// Monitors the core's result store and reload after the loader finishes, comparing them
// against a golden ALU result and raising a sticky pass/fail flag with an error code.
module alu_result_checker
  import alu_result_checker_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] RESULT_ADDR    = 32'h4,
  parameter logic [4:0]  LOAD_REG       = 5'd12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] op1,
  input  logic [11:0] op2,
  input  logic [2:0]  alu_op,
  input  logic        loader_done,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic        rf_we,
  input  logic [4:0]  rf_waddr,
  input  logic [31:0] rf_wdata,
  output logic        busy,
  output logic        pass,
  output logic        fail,
  output logic [1:0]  err_code,
  output logic [31:0] observed_result
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax  = '1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     expected_q, expected_d;
  logic [31:0]     observed_q, observed_d;
  logic [1:0]      err_q, err_d;
  logic            busy_q, busy_d;
  logic            pass_q, pass_d;
  logic            fail_q, fail_d;

  logic [31:0] golden;
  logic        st_hit, ld_hit, expired;

  alu_golden_model u_golden (
    .op1_i    (op1),
    .op2_i    (op2),
    .alu_op_i (alu_op),
    .result_o (golden)
  );

  assign st_hit  = dmem_we && (dmem_addr == RESULT_ADDR);
  assign ld_hit  = rf_we && (rf_waddr == LOAD_REG);
  assign expired = (cnt_q == CntLast);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    expected_d = expected_q;
    observed_d = observed_q;
    err_d      = err_q;

    unique case (state_q)
      StIdle: begin
        if (loader_done) begin
          expected_d = golden;
          cnt_d      = '0;
          state_d    = StWaitSt;
        end
      end
      StWaitSt: begin
        if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
        // A qualifying event wins over a simultaneous timeout.
        if (st_hit) begin
          observed_d = dmem_wdata;
          if (dmem_wdata == expected_q) begin
            state_d = StWaitLd;
          end else begin
            state_d = StFail;
            err_d   = ErrStore;
          end
        end else if (expired) begin
          state_d = StFail;
          err_d   = ErrTimeout;
        end
      end
      StWaitLd: begin
        if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
        if (ld_hit) begin
          if (rf_wdata == observed_q) begin
            state_d = StPass;
          end else begin
            state_d = StFail;
            err_d   = ErrReload;
          end
        end else if (expired) begin
          state_d = StFail;
          err_d   = ErrTimeout;
        end
      end
      StPass, StFail: ;
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StWaitSt) || (state_d == StWaitLd);
    pass_d = (state_d == StPass);
    fail_d = (state_d == StFail);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      expected_q <= '0;
      observed_q <= '0;
      err_q      <= ErrNone;
      busy_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      expected_q <= expected_d;
      observed_q <= observed_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
    end
  end

  assign busy            = busy_q;
  assign pass            = pass_q;
  assign fail            = fail_q;
  assign err_code        = err_q;
  assign observed_result = observed_q;

endmodule
